multicycle_control_fsm: RTL and testbench

Sequencing controller for the multi-cycle MIPS datapath. Each instruction is stepped through fetch, decode, execute, memory and writeback states. Per state, the block drives the ALU operation code, mux selects and write enables. It holds the shared ALU for multi-cycle multiplies and stalls on the memory ready handshake.

---
 rtl/mips_defs.sv | 116 +++++++++++
 rtl/alu_op_decode.sv | 54 +++++
 rtl/multicycle_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU codes, state numbers and datapath mux select codes.
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MUL_WAIT = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_MUL    = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_J      = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JR     = 4'd8,
        CLS_ILL    = 4'd9
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_JUMP = 4'd10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op)
            OP_LH, OP_SH: mem_size = SZ_HALF;
            OP_LB, OP_SB: mem_size = SZ_BYTE;
            default:      mem_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] reg_dst(input iclass_t cls);
        case (cls)
            CLS_R, CLS_MUL: reg_dst = DST_RD;
            CLS_JAL:        reg_dst = DST_RA;
            default:        reg_dst = DST_RT;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: (Op, Funct) -> ALU operation code and
// instruction class used by the controller's dispatch.
module alu_op_decode
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic [3:0] iclass
);

    iclass_t cls;

    always_comb begin
        alu_code = ALU_ADD;
        cls      = CLS_ILL;
        case (op)
            OP_RTYPE: begin
                cls = CLS_R;
                case (funct)
                    F_JR:  begin cls = CLS_JR; alu_code = ALU_JUMP; end
                    F_ADD: alu_code = ALU_ADD;
                    F_SUB: alu_code = ALU_SUB;
                    F_AND: alu_code = ALU_AND;
                    F_OR:  alu_code = ALU_OR;
                    F_NOR: alu_code = ALU_NOR;
                    F_XOR: alu_code = ALU_XOR;
                    F_SLL: alu_code = ALU_SLL;
                    F_SRL: alu_code = ALU_SRL;
                    F_SLT: alu_code = ALU_SLT;
                    default: cls = CLS_ILL;
                endcase
            end
            OP_MUL:  begin cls = CLS_MUL; alu_code = ALU_MUL; end
            OP_ADDI: begin cls = CLS_I; alu_code = ALU_ADD; end
            OP_ANDI: begin cls = CLS_I; alu_code = ALU_AND; end
            OP_ORI:  begin cls = CLS_I; alu_code = ALU_OR;  end
            OP_XORI: begin cls = CLS_I; alu_code = ALU_XOR; end
            OP_SLTI: begin cls = CLS_I; alu_code = ALU_SLT; end
            OP_LW, OP_LH, OP_LB: cls = CLS_LOAD;
            OP_SW, OP_SH, OP_SB: cls = CLS_STORE;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                cls      = CLS_BRANCH;
                alu_code = ALU_SUB;
            end
            OP_J:    begin cls = CLS_J;   alu_code = ALU_JUMP; end
            OP_JAL:  begin cls = CLS_JAL; alu_code = ALU_JUMP; end
            default: cls = CLS_ILL;
        endcase
    end

    assign iclass = cls;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_control_fsm
    import mips_defs::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemSize,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state, nxt;
    logic [3:0] cnt;
    iclass_t    cls_q, cls_d;
    logic [3:0] alu_q, alu_d, cls_raw;
    logic [1:0] size_q, regdst_q;

    alu_op_decode u_dec (
        .op       (Op),
        .funct    (Funct),
        .alu_code (alu_d),
        .iclass   (cls_raw)
    );

    assign cls_d = iclass_t'(cls_raw);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_FETCH;
            cnt      <= 4'd0;
            cls_q    <= CLS_R;
            alu_q    <= 4'd0;
            size_q   <= 2'd0;
            regdst_q <= 2'd0;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                cls_q    <= cls_d;
                alu_q    <= alu_d;
                size_q   <= mem_size(Op);
                regdst_q <= reg_dst(cls_d);
            end
            // Loaded on MUL_WAIT entry so the state lasts exactly MUL_CYCLES
            if (state == S_DECODE && nxt == S_MUL_WAIT)
                cnt <= 4'(MUL_CYCLES - 1);
            else if (state == S_MUL_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  if (MemReady) nxt = S_DECODE;
            S_DECODE: begin
                case (cls_d)
                    CLS_R:      nxt = S_EXEC_R;
                    CLS_I:      nxt = S_EXEC_I;
                    CLS_MUL:    nxt = S_MUL_WAIT;
                    CLS_LOAD,
                    CLS_STORE:  nxt = S_MEM_ADDR;
                    CLS_BRANCH: nxt = S_BRANCH;
                    CLS_J,
                    CLS_JAL,
                    CLS_JR:     nxt = S_JUMP;
                    default:    nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MUL_WAIT: if (cnt == 4'd0) nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = (cls_q == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (MemReady) nxt = S_MEM_WB;
            S_MEM_WR:   if (MemReady) nxt = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCS_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemSize     = SZ_WORD;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = DST_RT;
        MemToReg    = M2R_ALUOUT;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUControl  = ALU_ADD;
        Illegal     = 1'b0;
        State       = 4'd0;
        if (!Reset) begin
            State = state;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE:   ALUSrcB = SRCB_IMM_SH;
                S_EXEC_R: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = alu_q;
                end
                S_EXEC_I: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = alu_q;
                end
                S_MUL_WAIT: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_MUL;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    MemSize = size_q;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = M2R_MDR;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    MemSize  = size_q;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = regdst_q;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUControl  = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    ALUControl = ALU_JUMP;
                    PCSource   = (cls_q == CLS_JR) ? PCS_RS : PCS_JUMP;
                    if (cls_q == CLS_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = regdst_q;
                        MemToReg = M2R_PC;
                    end
                end
                S_TRAP:  Illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vector table plus
// hand sequences for trap, reset mid-instruction and MUL_CYCLES=1.
module tb_multicycle_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset, Reset1, MemReady;
    logic [5:0] Op, Funct;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
    logic [1:0] PCSource, MemSize, RegDst, MemToReg, ALUSrcB;
    logic [3:0] ALUControl, State;

    logic       u1_PCWrite, u1_PCWriteCond, u1_IorD, u1_MemRead, u1_MemWrite, u1_IRWrite, u1_RegWrite, u1_ALUSrcA, u1_Illegal;
    logic [1:0] u1_PCSource, u1_MemSize, u1_RegDst, u1_MemToReg, u1_ALUSrcB;
    logic [3:0] u1_ALUControl, u1_State;

    always #5 Clk = ~Clk;

    multicycle_control_fsm #(.MUL_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    multicycle_control_fsm #(.MUL_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset1), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(u1_PCWrite), .PCWriteCond(u1_PCWriteCond), .PCSource(u1_PCSource), .IorD(u1_IorD),
        .MemRead(u1_MemRead), .MemWrite(u1_MemWrite), .MemSize(u1_MemSize), .IRWrite(u1_IRWrite),
        .RegWrite(u1_RegWrite), .RegDst(u1_RegDst), .MemToReg(u1_MemToReg), .ALUSrcA(u1_ALUSrcA),
        .ALUSrcB(u1_ALUSrcB), .ALUControl(u1_ALUControl), .Illegal(u1_Illegal), .State(u1_State)
    );

    // en  = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}
    // sel = {PCSource, IorD, MemSize, RegDst, MemToReg, ALUSrcA, ALUSrcB}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [3:0]  st;
        logic [3:0]  alu;
        logic [5:0]  en;
        logic [11:0] sel;
        logic        ill;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_fail = 0;

    localparam logic [11:0] SEL_FETCH = 12'b00_0_00_00_00_0_01;
    localparam logic [11:0] SEL_DEC   = 12'b00_0_00_00_00_0_11;
    localparam logic [11:0] SEL_RS_RT = 12'b00_0_00_00_00_1_00;
    localparam logic [11:0] SEL_RS_IM = 12'b00_0_00_00_00_1_10;
    localparam logic [11:0] SEL_WB_RD = 12'b00_0_00_01_00_0_00;
    localparam logic [11:0] SEL_ZERO  = 12'b0;
    localparam logic [5:0]  EN_FETCH  = 6'b101100;

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic m,
                       input logic [3:0] s, input logic [3:0] a, input logic [5:0] e,
                       input logic [11:0] sl, input logic i);
        vec_t v;
        v.rst = r; v.op = o; v.fn = f; v.rdy = m;
        v.st = s; v.alu = a; v.en = e; v.sel = sl; v.ill = i;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] s, input logic [3:0] a,
                             input logic [5:0] e, input logic [11:0] sl, input logic i);
        chk({tag, " State"}, int'(State), int'(s));
        chk({tag, " ALUControl"}, int'(ALUControl), int'(a));
        chk({tag, " enables"}, int'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), int'(e));
        chk({tag, " selects"}, int'({PCSource, IorD, MemSize, RegDst, MemToReg, ALUSrcA, ALUSrcB}), int'(sl));
        chk({tag, " Illegal"}, int'(Illegal), int'(i));
    endtask

    // Advance one clock, drive inputs just after the edge, sample at negedge.
    task automatic tick(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic m, input logic r1);
        @(posedge Clk);
        #1;
        Reset = r; Op = o; Funct = f; MemReady = m; Reset1 = r1;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Reset1 = 1'b1; Op = 6'd0; Funct = 6'd0; MemReady = 1'b0;

        add(1, 6'h00, 6'h00, 1, 0, 0, 6'b0, SEL_ZERO, 0);
        add(1, 6'h00, 6'h00, 1, 0, 0, 6'b0, SEL_ZERO, 0);
        // sub
        add(0, 6'b000000, 6'b100010, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b000000, 6'b100010, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b000000, 6'b100010, 1, 2, 1, 6'b0, SEL_RS_RT, 0);
        add(0, 6'b000000, 6'b100010, 1, 9, 0, 6'b000001, SEL_WB_RD, 0);
        // lw with two wait cycles in MEM_RD
        add(0, 6'b100011, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b100011, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b100011, 6'h00, 0, 5, 0, 6'b0, SEL_RS_IM, 0);
        add(0, 6'b100011, 6'h00, 0, 6, 0, 6'b000100, 12'b00_1_00_00_00_0_00, 0);
        add(0, 6'b100011, 6'h00, 0, 6, 0, 6'b000100, 12'b00_1_00_00_00_0_00, 0);
        add(0, 6'b100011, 6'h00, 1, 6, 0, 6'b000100, 12'b00_1_00_00_00_0_00, 0);
        add(0, 6'b100011, 6'h00, 1, 7, 0, 6'b000001, 12'b00_0_00_00_01_0_00, 0);
        // sb
        add(0, 6'b101000, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b101000, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b101000, 6'h00, 1, 5, 0, 6'b0, SEL_RS_IM, 0);
        add(0, 6'b101000, 6'h00, 1, 8, 0, 6'b000010, 12'b00_1_10_00_00_0_00, 0);
        // ori
        add(0, 6'b001101, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b001101, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b001101, 6'h00, 1, 3, 4, 6'b0, SEL_RS_IM, 0);
        add(0, 6'b001101, 6'h00, 1, 9, 0, 6'b000001, SEL_ZERO, 0);
        // mul, MUL_CYCLES=4
        add(0, 6'b011100, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b011100, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        for (int k = 0; k < 4; k++)
            add(0, 6'b011100, 6'h00, 1, 4, 2, 6'b0, SEL_RS_RT, 0);
        add(0, 6'b011100, 6'h00, 1, 9, 0, 6'b000001, SEL_WB_RD, 0);
        // beq with one fetch stall
        add(0, 6'b000100, 6'h00, 0, 0, 0, 6'b000100, SEL_FETCH, 0);
        add(0, 6'b000100, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b000100, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b000100, 6'h00, 1, 10, 1, 6'b010000, 12'b01_0_00_00_00_1_00, 0);
        // jal
        add(0, 6'b000011, 6'h00, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b000011, 6'h00, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b000011, 6'h00, 1, 11, 10, 6'b100001, 12'b10_0_00_10_10_0_00, 0);
        // jr
        add(0, 6'b000000, 6'b001000, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b000000, 6'b001000, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b000000, 6'b001000, 1, 11, 10, 6'b100000, 12'b11_0_00_00_00_0_00, 0);
        // slt
        add(0, 6'b000000, 6'b101010, 1, 0, 0, EN_FETCH, SEL_FETCH, 0);
        add(0, 6'b000000, 6'b101010, 1, 1, 0, 6'b0, SEL_DEC, 0);
        add(0, 6'b000000, 6'b101010, 1, 2, 9, 6'b0, SEL_RS_RT, 0);
        add(0, 6'b000000, 6'b101010, 1, 9, 0, 6'b000001, SEL_WB_RD, 0);

        foreach (tv[i]) begin
            tick(tv[i].rst, tv[i].op, tv[i].fn, tv[i].rdy, 1'b1);
            check_all($sformatf("vec%0d", i), tv[i].st, tv[i].alu, tv[i].en, tv[i].sel, tv[i].ill);
        end

        // Illegal opcode: TRAP is sticky, then reset mid-TRAP
        tick(0, 6'b111111, 6'h00, 1, 1);
        check_all("trap fetch", 0, 0, EN_FETCH, SEL_FETCH, 0);
        tick(0, 6'b111111, 6'h00, 1, 1);
        check_all("trap decode", 1, 0, 6'b0, SEL_DEC, 0);
        for (int k = 0; k < 20; k++) begin
            tick(0, 6'b111111, 6'h00, 1, 1);
            check_all($sformatf("trap hold%0d", k), 12, 0, 6'b0, SEL_ZERO, 1);
        end
        tick(1, 6'b111111, 6'h00, 1, 1);
        check_all("trap in reset", 0, 0, 6'b0, SEL_ZERO, 0);
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("trap after reset", 0, 0, EN_FETCH, SEL_FETCH, 0);

        // Reset mid-MUL_WAIT, then a full mul must still take 4 cycles
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst decode", 1, 0, 6'b0, SEL_DEC, 0);
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst mul0", 4, 2, 6'b0, SEL_RS_RT, 0);
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst mul1", 4, 2, 6'b0, SEL_RS_RT, 0);
        tick(1, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst in reset", 0, 0, 6'b0, SEL_ZERO, 0);
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst fetch", 0, 0, EN_FETCH, SEL_FETCH, 0);
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst redecode", 1, 0, 6'b0, SEL_DEC, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 6'b011100, 6'h00, 1, 1);
            check_all($sformatf("mulrst again%0d", k), 4, 2, 6'b0, SEL_RS_RT, 0);
        end
        tick(0, 6'b011100, 6'h00, 1, 1);
        check_all("mulrst wb", 9, 0, 6'b000001, SEL_WB_RD, 0);

        // MUL_CYCLES=1 instance: 0,1,4,9 then back to FETCH
        tick(1, 6'b011100, 6'h00, 1, 1);
        chk("mul1 reset State", int'(u1_State), 0);
        tick(1, 6'b011100, 6'h00, 1, 0);
        chk("mul1 fetch State", int'(u1_State), 0);
        chk("mul1 fetch IRWrite", int'(u1_IRWrite), 1);
        tick(1, 6'b011100, 6'h00, 1, 0);
        chk("mul1 decode State", int'(u1_State), 1);
        tick(1, 6'b011100, 6'h00, 1, 0);
        chk("mul1 mul State", int'(u1_State), 4);
        chk("mul1 mul ALUControl", int'(u1_ALUControl), 2);
        tick(1, 6'b011100, 6'h00, 1, 0);
        chk("mul1 wb State", int'(u1_State), 9);
        chk("mul1 wb RegWrite", int'({u1_RegWrite, u1_RegDst}), 3'b101);
        tick(1, 6'b011100, 6'h00, 1, 0);
        chk("mul1 next fetch State", int'(u1_State), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
